pc_fetch_unit: RTL and testbench

Parametrised program-counter and instruction-fetch block that replaces the fixed PC-plus-4 and jump/branch adder logic in the single-cycle CPU. It issues fetch requests to an instruction memory with variable latency and holds each fetched instruction for the decode and execute stages. It then resolves the next PC from jump, branch and ZERO inputs, and supports pipeline stall.

---
 rtl/pc_fetch_unit.sv | 202 ++++++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch unit: fetch/execute sequencing against a
// variable-latency instruction memory. Optional return-address stack: PC_FETCH_RAS_EN.
module pc_fetch_unit #(
    parameter int ADDR_W      = 32,
    parameter int INSTR_W     = 32,
    parameter int OFFSET_W    = 8,
    parameter int INSTR_BYTES = 4,
    parameter int RAS_DEPTH   = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    output logic                IMEM_READ,
    output logic [ADDR_W-1:0]   IMEM_ADDR,
    input  logic                IMEM_READY,
    input  logic [INSTR_W-1:0]  IMEM_DATA,
    output logic [INSTR_W-1:0]  INSTRUCTION,
    output logic                INSTR_VALID,
    input  logic                STALL,
    input  logic                JUMP,
    input  logic                BRANCH,
    input  logic                ZERO,
    input  logic [OFFSET_W-1:0] OFFSET,
    output logic [ADDR_W-1:0]   PC,
`ifdef PC_FETCH_RAS_EN
    input  logic                CALL,
    input  logic                RET,
    output logic                RAS_ERR,
`endif
    output logic [15:0]         RETIRED
);

    localparam logic [0:0] S_FETCH = 1'b0;
    localparam logic [0:0] S_EXEC  = 1'b1;
    localparam int         SHIFT_W = $clog2(INSTR_BYTES);

    generate
        if (((INSTR_BYTES & (INSTR_BYTES - 1)) != 0) || (OFFSET_W >= ADDR_W) || (RAS_DEPTH < 1)) begin : g_bad_param
            $error("pc_fetch_unit: INSTR_BYTES must be a power of 2, OFFSET_W < ADDR_W, RAS_DEPTH >= 1");
        end
    endgenerate

    // Word offset is relative to the sequential PC and scaled to bytes.
    function automatic logic [ADDR_W-1:0] branch_target(input logic [ADDR_W-1:0] seq,
                                                        input logic [OFFSET_W-1:0] off);
        logic [ADDR_W-1:0] ext;
        ext = {{(ADDR_W - OFFSET_W){off[OFFSET_W-1]}}, off};
        return seq + (ext << SHIFT_W);
    endfunction

    logic [0:0]         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic [15:0]        retired_q, retired_d;
    logic [ADDR_W-1:0]  seq_pc_s, tgt_pc_s, next_pc_s;
    logic               exec_fire_s;

    assign seq_pc_s    = pc_q + ADDR_W'(INSTR_BYTES);
    assign tgt_pc_s    = branch_target(seq_pc_s, OFFSET);
    assign exec_fire_s = (state_q == S_EXEC) && !STALL;

`ifdef PC_FETCH_RAS_EN
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RAS_DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        return (p == {PTR_W{1'b0}}) ? PTR_W'(RAS_DEPTH - 1) : p - PTR_W'(1);
    endfunction

    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_top_q, ras_top_d, ras_wr_idx_s;
    logic [CNT_W-1:0]  ras_cnt_q, ras_cnt_d;
    logic              ras_err_q, ras_err_d, ras_push_s;

    assign ras_wr_idx_s = ptr_inc(ras_top_q);

    // Stack pointer, occupancy and sticky error; a full push drops the oldest entry.
    always_comb begin
        ras_top_d  = ras_top_q;
        ras_cnt_d  = ras_cnt_q;
        ras_err_d  = ras_err_q;
        ras_push_s = 1'b0;
        if (exec_fire_s && RET) begin
            if (ras_cnt_q != {CNT_W{1'b0}}) begin
                ras_top_d = ptr_dec(ras_top_q);
                ras_cnt_d = ras_cnt_q - CNT_W'(1);
            end else begin
                ras_err_d = 1'b1;
            end
        end else if (exec_fire_s && CALL) begin
            ras_push_s = 1'b1;
            ras_top_d  = ras_wr_idx_s;
            ras_cnt_d  = (ras_cnt_q == CNT_W'(RAS_DEPTH)) ? ras_cnt_q : ras_cnt_q + CNT_W'(1);
        end else begin
            ras_push_s = 1'b0;
        end
    end

    // Return-address stack registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ras_top_q <= {PTR_W{1'b0}};
            ras_cnt_q <= {CNT_W{1'b0}};
            ras_err_q <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= {ADDR_W{1'b0}};
        end else begin
            ras_top_q <= ras_top_d;
            ras_cnt_q <= ras_cnt_d;
            ras_err_q <= ras_err_d;
            if (ras_push_s) ras_q[ras_wr_idx_s] <= seq_pc_s;
        end
    end

    // Next-PC priority: RET > CALL > JUMP > taken BRANCH > sequential.
    always_comb begin
        next_pc_s = seq_pc_s;
        if (RET) begin
            next_pc_s = (ras_cnt_q != {CNT_W{1'b0}}) ? ras_q[ras_top_q] : seq_pc_s;
        end else if (CALL || JUMP || (BRANCH && ZERO)) begin
            next_pc_s = tgt_pc_s;
        end else begin
            next_pc_s = seq_pc_s;
        end
    end

    assign RAS_ERR = ras_err_q;
`else
    // Next-PC: JUMP or taken BRANCH selects the target, otherwise sequential.
    always_comb begin
        next_pc_s = seq_pc_s;
        if (JUMP || (BRANCH && ZERO)) begin
            next_pc_s = tgt_pc_s;
        end else begin
            next_pc_s = seq_pc_s;
        end
    end
`endif

    // Fetch/execute sequencing and next-state values.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        retired_d = retired_q;
        case (state_q)
            S_FETCH: begin
                if (IMEM_READY) begin
                    instr_d = IMEM_DATA;
                    valid_d = 1'b1;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                if (!STALL) begin
                    pc_d      = next_pc_s;
                    retired_d = retired_q + 16'd1;
                    valid_d   = 1'b0;
                    state_d   = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            default: begin
                state_d = S_FETCH;
                valid_d = 1'b0;
            end
        endcase
    end

    // Core state registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_FETCH;
            pc_q      <= {ADDR_W{1'b0}};
            instr_q   <= {INSTR_W{1'b0}};
            valid_q   <= 1'b0;
            retired_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            retired_q <= retired_d;
        end
    end

    // Fetch request is a decode of the registered state, forced low during reset.
    assign IMEM_READ   = (state_q == S_FETCH) && !RESET;
    assign IMEM_ADDR   = pc_q;
    assign PC          = pc_q;
    assign INSTRUCTION = instr_q;
    assign INSTR_VALID = valid_q;
    assign RETIRED     = retired_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus a randomized run
// against a next-PC reference model. RAS scenario built only with PC_FETCH_RAS_EN.
module tb_pc_fetch_unit;
    logic        clk, rst, imem_ready, stall, jump, branch, zero;
    logic [31:0] imem_data;
    logic [7:0]  offset;
    wire         imem_read, instr_valid;
    wire  [31:0] imem_addr, instruction, pc;
    wire  [15:0] retired;
`ifdef PC_FETCH_RAS_EN
    logic        call, ret;
    wire         ras_err;
`endif
    int n_checks = 0;
    int n_fail   = 0;

    pc_fetch_unit dut (
        .CLK(clk), .RESET(rst), .IMEM_READ(imem_read), .IMEM_ADDR(imem_addr),
        .IMEM_READY(imem_ready), .IMEM_DATA(imem_data), .INSTRUCTION(instruction),
        .INSTR_VALID(instr_valid), .STALL(stall), .JUMP(jump), .BRANCH(branch),
        .ZERO(zero), .OFFSET(offset), .PC(pc),
`ifdef PC_FETCH_RAS_EN
        .CALL(call), .RET(ret), .RAS_ERR(ras_err),
`endif
        .RETIRED(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Spec rule: seq = PC+4, tgt = seq + offset*4, taken on JUMP or BRANCH&ZERO, mod 2^32.
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic j, b, z,
                                             input logic [7:0] off);
        longint seq, tgt, r;
        logic [31:0] res;
        seq = longint'(cur) + 64'sd4;
        tgt = seq + longint'($signed(off)) * 64'sd4;
        r   = (j || (b && z)) ? tgt : seq;
        res = r[31:0];
        return res;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl;
        jump = 1'b0; branch = 1'b0; zero = 1'b0; offset = 8'd0; stall = 1'b0;
`ifdef PC_FETCH_RAS_EN
        call = 1'b0; ret = 1'b0;
`endif
    endtask

    task automatic do_reset;
        clear_ctrl();
        imem_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One instruction with a ready memory and no stall.
    task automatic run_instr(input logic j, b, z, input logic [7:0] off);
        imem_ready = 1'b1;
        imem_data  = $urandom;
        tick();
        imem_ready = 1'b0;
        jump = j; branch = b; zero = z; offset = off;
        tick();
        clear_ctrl();
    endtask

    task automatic test_reset;
        clear_ctrl();
        imem_ready = 1'b1;
        imem_data  = $urandom;
        rst = 1'b1;
        #1;
        tick();
        if (pc !== 32'd0) begin $display("FAIL reset_pc: got %h want %h", pc, 32'd0); n_fail++; end
        n_checks++;
        if (imem_read !== 1'b0) begin $display("FAIL reset_read: got %b want 0", imem_read); n_fail++; end
        n_checks++;
        if ({instr_valid, retired, instruction} !== {1'b0, 16'd0, 32'd0}) begin
            $display("FAIL reset_regs: valid %b retired %0d instr %h want 0/0/0", instr_valid, retired, instruction); n_fail++;
        end
        n_checks++;
        rst = 1'b0;
        #1;
        if (imem_read !== 1'b1) begin $display("FAIL release_read: got %b want 1", imem_read); n_fail++; end
        n_checks++;
    endtask

    task automatic test_zero_latency;
        logic [31:0] d;
        logic [31:0] exp_pc;
        imem_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            d = $urandom;
            imem_data = d;
            tick();
            exp_pc = 32'(4 * (i / 2));
            if ({pc, imem_addr} !== {exp_pc, exp_pc}) begin
                $display("FAIL zl_pc[%0d]: pc %h addr %h want %h", i, pc, imem_addr, exp_pc); n_fail++;
            end
            n_checks++;
            if ({instr_valid, imem_read, retired} !== {1'(i % 2), 1'(1 - i % 2), 16'(i / 2)}) begin
                $display("FAIL zl_ctl[%0d]: valid %b read %b retired %0d want %0d/%0d/%0d",
                         i, instr_valid, imem_read, retired, i % 2, 1 - i % 2, i / 2); n_fail++;
            end
            n_checks++;
            if ((i % 2) == 1) begin
                if (instruction !== d) begin $display("FAIL zl_instr[%0d]: got %h want %h", i, instruction, d); n_fail++; end
                n_checks++;
            end
        end
        imem_ready = 1'b0;
    endtask

    task automatic test_wait_states;
        logic [31:0] d;
        do_reset();
        run_instr(1'b0, 1'b0, 1'b0, 8'd0);
        run_instr(1'b0, 1'b0, 1'b0, 8'd0);
        for (int c = 1; c <= 3; c++) begin
            jump = 1'($urandom); branch = 1'($urandom); zero = 1'($urandom); offset = 8'($urandom);
            imem_ready = (c == 3);
            d = $urandom;
            imem_data = d;
            tick();
            if ({pc, instr_valid} !== {32'd8, 1'(c == 3)}) begin
                $display("FAIL ws_cycle%0d: pc %h valid %b want 00000008/%0d", c, pc, instr_valid, c == 3); n_fail++;
            end
            n_checks++;
        end
        if (instruction !== d) begin $display("FAIL ws_instr: got %h want %h", instruction, d); n_fail++; end
        n_checks++;
        clear_ctrl();
        stall = 1'b1;
        imem_ready = 1'b1;
        imem_data = ~d;
        tick();
        if ({instruction, pc} !== {d, 32'd8}) begin
            $display("FAIL ws_exec_ignore_ready: instr %h pc %h want %h/00000008", instruction, pc, d); n_fail++;
        end
        n_checks++;
        stall = 1'b0;
        imem_ready = 1'b0;
        tick();
    endtask

    task automatic test_branch;
        do_reset();
        for (int i = 0; i < 4; i++) run_instr(1'b0, 1'b0, 1'b0, 8'd0);
        run_instr(1'b0, 1'b1, 1'b1, 8'hFE);
        if (pc !== 32'd12) begin $display("FAIL br_taken: got %h want %h", pc, 32'd12); n_fail++; end
        n_checks++;
        run_instr(1'b0, 1'b0, 1'b0, 8'd0);
        run_instr(1'b0, 1'b1, 1'b0, 8'hFE);
        if (pc !== 32'd20) begin $display("FAIL br_not_taken: got %h want %h", pc, 32'd20); n_fail++; end
        n_checks++;
        run_instr(1'b1, 1'b0, 1'b0, 8'hFE);
        run_instr(1'b1, 1'b1, 1'b0, 8'd3);
        if (pc !== 32'd32) begin $display("FAIL jump_wins: got %h want %h", pc, 32'd32); n_fail++; end
        n_checks++;
    endtask

    task automatic test_stall_wrap;
        logic [31:0] held;
        do_reset();
        run_instr(1'b1, 1'b0, 1'b0, 8'hFE);
        if (pc !== 32'hFFFF_FFFC) begin $display("FAIL wrap_down: got %h want fffffffc", pc); n_fail++; end
        n_checks++;
        imem_ready = 1'b1;
        imem_data = $urandom;
        held = imem_data;
        tick();
        imem_ready = 1'b0;
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            jump = 1'($urandom); offset = 8'($urandom);
            tick();
            if ({pc, instruction, retired, instr_valid} !== {32'hFFFF_FFFC, held, 16'd1, 1'b1}) begin
                $display("FAIL stall_hold%0d: pc %h instr %h retired %0d valid %b", c, pc, instruction, retired, instr_valid); n_fail++;
            end
            n_checks++;
        end
        clear_ctrl();
        tick();
        if ({pc, retired} !== {32'd0, 16'd2}) begin $display("FAIL wrap_up: pc %h retired %0d want 0/2", pc, retired); n_fail++; end
        n_checks++;
    endtask

    task automatic test_async_reset;
        do_reset();
        run_instr(1'b1, 1'b0, 1'b0, 8'd9);
        if ({pc, imem_read} !== {32'd40, 1'b1}) begin $display("FAIL ar_setup: pc %h read %b want 00000028/1", pc, imem_read); n_fail++; end
        n_checks++;
        #3;
        rst = 1'b1;
        #1;
        if ({pc, imem_read, retired} !== {32'd0, 1'b0, 16'd0}) begin
            $display("FAIL ar_immediate: pc %h read %b retired %0d want 0/0/0", pc, imem_read, retired); n_fail++;
        end
        n_checks++;
        tick();
        rst = 1'b0;
    endtask

`ifdef PC_FETCH_RAS_EN
    task automatic test_ras;
        do_reset();
        run_instr(1'b0, 1'b0, 1'b0, 8'd0);
        run_instr(1'b0, 1'b0, 1'b0, 8'd0);
        call = 1'b1;
        run_instr(1'b0, 1'b0, 1'b0, 8'd4);
        if (pc !== 32'd28) begin $display("FAIL ras_call: got %h want %h", pc, 32'd28); n_fail++; end
        n_checks++;
        ret = 1'b1;
        run_instr(1'b0, 1'b0, 1'b0, 8'd0);
        if ({pc, ras_err} !== {32'd12, 1'b0}) begin $display("FAIL ras_ret: pc %h err %b want 0000000c/0", pc, ras_err); n_fail++; end
        n_checks++;
        ret = 1'b1;
        run_instr(1'b0, 1'b0, 1'b0, 8'd0);
        if ({pc, ras_err} !== {32'd16, 1'b1}) begin $display("FAIL ras_empty: pc %h err %b want 00000010/1", pc, ras_err); n_fail++; end
        n_checks++;
        run_instr(1'b0, 1'b0, 1'b0, 8'd0);
        if (ras_err !== 1'b1) begin $display("FAIL ras_sticky: got %b want 1", ras_err); n_fail++; end
        n_checks++;
    endtask
`endif

    task automatic test_random;
        logic [31:0] exp_pc, d;
        logic        j, b, z;
        logic [7:0]  off;
        int          exp_ret;
        do_reset();
        exp_pc  = 32'd0;
        exp_ret = 0;
        for (int n = 0; n < 150; n++) begin
            for (int w = $urandom_range(0, 2); w > 0; w--) begin
                imem_ready = 1'b0;
                jump = 1'($urandom); branch = 1'($urandom); zero = 1'($urandom); offset = 8'($urandom);
                tick();
                if ({pc, instr_valid, imem_read} !== {exp_pc, 1'b0, 1'b1}) begin
                    $display("FAIL rnd_wait[%0d]: pc %h valid %b read %b want %h/0/1", n, pc, instr_valid, imem_read, exp_pc); n_fail++;
                end
                n_checks++;
            end
            imem_ready = 1'b1;
            d = $urandom;
            imem_data = d;
            tick();
            imem_ready = 1'($urandom);
            for (int s = $urandom_range(0, 2); s > 0; s--) begin
                stall = 1'b1;
                jump = 1'($urandom); branch = 1'($urandom); zero = 1'($urandom); offset = 8'($urandom);
                tick();
            end
            if ({pc, instruction, instr_valid, retired} !== {exp_pc, d, 1'b1, 16'(exp_ret)}) begin
                $display("FAIL rnd_exec[%0d]: pc %h instr %h valid %b retired %0d want %h/%h/1/%0d",
                         n, pc, instruction, instr_valid, retired, exp_pc, d, exp_ret); n_fail++;
            end
            n_checks++;
            j = 1'($urandom); b = 1'($urandom); z = 1'($urandom); off = 8'($urandom);
            stall = 1'b0; jump = j; branch = b; zero = z; offset = off;
            tick();
            exp_pc  = ref_next(exp_pc, j, b, z, off);
            exp_ret = exp_ret + 1;
            if ({pc, retired, instr_valid} !== {exp_pc, 16'(exp_ret), 1'b0}) begin
                $display("FAIL rnd_next[%0d]: pc %h retired %0d valid %b want %h/%0d/0", n, pc, retired, instr_valid, exp_pc, exp_ret); n_fail++;
            end
            n_checks++;
            clear_ctrl();
        end
    endtask

    initial begin
        imem_data = 32'd0;
        imem_ready = 1'b0;
        rst = 1'b1;
        clear_ctrl();
        test_reset();
        test_zero_latency();
        test_wait_states();
        test_branch();
        test_stall_wrap();
        test_async_reset();
`ifdef PC_FETCH_RAS_EN
        test_ras();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
